sync_up_counter: RTL and testbench
==================================

# sync_up_counter

Synchronous modulo-N up counter: the counting-up counterpart to the team's asynchronous down counter, reusing the same `clk`/`rst`/`q` port naming. It counts 0 → MODULUS-1 on enabled clock edges and then wraps or saturates. It supports parallel load, and exposes a terminal-count output plus a cascade carry so that wider counters can be built by chaining instances. A sticky overflow flag records wraps for software or a supervising FSM.

## Interface
- `WIDTH`, default 4: counter width in bits, range 1..16.
- `MODULUS`, default 16: count range is 0..MODULUS-1; legal range is 2..2^WIDTH.
- `SATURATE`, default 0:
  - 0: wrap from MODULUS-1 to 0.
  - 1: hold at MODULUS-1.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `en`, input, 1: count enable; advance by one on this edge.
- `load`, input, 1: parallel load strobe.
- `load_val`, input, WIDTH: value to load.
- `clr_ovf`, input, 1: clears the sticky overflow flag.
- `q`, output, WIDTH: current count (registered).
- `tc`, output, 1: terminal count, combinational, equal to (q == MODULUS-1).
- `co`, output, 1: cascade carry, combinational, equal to tc & en & ~load.
- `ovf`, output, 1: sticky flag, set on every wrap (SATURATE=0) or every blocked increment at MODULUS-1 (SATURATE=1).
- `load_err`, output, 1: registered one-cycle pulse when a load is clamped.

## Operation
- **Reset values:** q=0, ovf=0, load_err=0. Hence tc=0 and co=0 (given MODULUS ≥ 2).
- **Edge priority, highest first:** rst > load > en > hold.
- **rst=1:** all registers take their reset values. load, en and clr_ovf are ignored.
- **load=1:**
  - If load_val < MODULUS: q ← load_val, load_err ← 0.
  - Otherwise: q ← MODULUS-1 and load_err ← 1 for exactly one cycle.
  - en is ignored on a load edge. A load never sets ovf.
- **en=1, load=0:**
  - If q < MODULUS-1: q ← q+1.
  - If q == MODULUS-1 and SATURATE=0: q ← 0 and ovf ← 1.
  - If q == MODULUS-1 and SATURATE=1: q holds and ovf ← 1.
- **en=0, load=0:** q holds.
- **ovf:**
  - clr_ovf=1 clears it.
  - If a set condition and clr_ovf coincide on the same edge, set wins and ovf reads 1.
- **load_err:** is 0 on every edge without a clamped load.
- **Arithmetic:** the increment is computed at WIDTH bits and the compare is against the constant MODULUS-1. No intermediate value exceeds WIDTH+1 bits.
- **Non-power-of-two modulus** (e.g. MODULUS=10, WIDTH=4): codes 10..15 are unreachable except via an illegal load, which is clamped.
- **Cascading:** connect stage N `co` to stage N+1 `en`. The upper stage advances on the same edge that the lower stage wraps.
- **Illegal parameters:** elaboration fails, via a generate-time check or `$error`, if MODULUS < 2 or MODULUS > 2^WIDTH.

## Timing
- **Latency:** q, ovf and load_err change one cycle after the sampled edge. tc and co follow q/en/load combinationally in the same cycle.
- **Count period:** with en held high, q reaches MODULUS-1 after MODULUS-1 edges and returns to 0 on edge MODULUS (SATURATE=0).
- **Reset mid-count:** q=0 on the edge after rst is sampled high. Counting resumes on the first edge with rst=0 and en=1.
- **Load at terminal count with en=1:** load wins, no wrap occurs, ovf is unchanged, and co=0 in that cycle.
- **Back-to-back loads:** each edge takes the new load_val. load_err pulses independently per clamped edge.

## Structure
- **Shared package `counter_pkg`:**
  - Function `clog2_min1(n)`.
  - Localparam type `cnt_mode_e` with values `WRAP` and `SAT`.
  - Parameter legality check function, reused by the existing down counter.
- **One sub-module, `up_count_core`:** holds the q register, the priority mux and the terminal compare.
- **Top level:** the ovf and load_err registers, and the co/tc outputs.
- **RTL size:** about 150–200 lines total.

## Test plan
1. **Reset and free-run:** rst=1 for 2 cycles, then en=1 with WIDTH=4, MODULUS=16. Required: q steps 0,1,…,15,0; tc=1 only while q=15; ovf sets on the edge where q goes 15→0.
2. **Modulo 10 with saturate:** MODULUS=10, SATURATE=1, en=1 for 14 cycles. Required: q stops at 9; tc stays 1 from then on; ovf=1 from the first blocked edge onward.
3. **Load and clamp:**
   - load=1, load_val=7 (MODULUS=10): q=7 next cycle, load_err=0.
   - load_val=12: q=9 and load_err=1 for one cycle only.
4. **Priority:**
   - With q=15, assert load=1 (load_val=3) and en=1 together: q=3, ovf unchanged, co=0.
   - Assert rst with load on the same edge: q=0.
5. **ovf set/clear race:** q=15, en=1, clr_ovf=1 on the same edge: ovf=1. Then clr_ovf=1 with en=0: ovf=0.
6. **Cascade:** two 4-bit instances chained (co→en), en=1 for 300 cycles from reset. Required: the combined {hi,lo} value equals the cycle count mod 256 at every cycle; hi increments exactly when lo wraps 15→0.

Source files
------------

// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_pkg
// Brief    : Shared types and helpers for the counter family (up and down).
// Revision : 1.0 - initial release
// ============================================================================
package counter_pkg;

  // Terminal behaviour of the count: roll over to zero or stick at the top.
  typedef enum logic {
    WRAP = 1'b0,
    SAT  = 1'b1
  } cnt_mode_e;

  // Bits needed to encode n distinct values, never less than one.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Width must be 1..16 and the modulus must fit in 2..2^width.
  function automatic bit params_legal(input int width, input int modulus);
    return (width >= 1) && (width <= 16) &&
           (modulus >= 2) && (modulus <= (1 << width));
  endfunction

endpackage : counter_pkg
`default_nettype wire

// File: rtl/up_count_core.sv
`default_nettype none
// ============================================================================
// Module   : up_count_core
// Brief    : Count register with load/enable priority mux and terminal compare.
// Revision : 1.0 - initial release
// ============================================================================
module up_count_core
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf_set,
  output logic             clamp
);

  // Largest reachable code, and the modulus held one bit wider so 2^WIDTH fits.
  localparam logic [WIDTH-1:0] c_max  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   c_mod  = (WIDTH + 1)'(MODULUS);
  localparam cnt_mode_e        c_mode = (SATURATE != 0) ? SAT : WRAP;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_inc;
  logic             w_at_max;
  logic             w_load_ok;

  assign w_at_max  = (r_q == c_max);
  assign w_load_ok = ({1'b0, load_val} < c_mod);
  assign w_inc     = r_q + WIDTH'(1);

  // Next count: load beats enable; out-of-range loads clamp to the top code.
  always_comb begin
    w_q_nxt = r_q;
    if (load) begin
      w_q_nxt = w_load_ok ? load_val : c_max;
    end else if (en) begin
      if (!w_at_max) begin
        w_q_nxt = w_inc;
      end else if (c_mode == WRAP) begin
        w_q_nxt = '0;
      end
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else begin
      r_q <= w_q_nxt;
    end
  end

  assign q       = r_q;
  assign tc      = w_at_max;
  // An enabled edge at the top code is a wrap or a blocked increment.
  assign ovf_set = en & ~load & w_at_max;
  assign clamp   = load & ~w_load_ok;

endmodule : up_count_core
`default_nettype wire

// File: rtl/sync_up_counter.sv
`default_nettype none
// ============================================================================
// Module   : sync_up_counter
// Brief    : Synchronous modulo-N up counter with load, clamp flag, sticky
//            overflow and cascade carry.
// Revision : 1.0 - initial release
// ============================================================================
module sync_up_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             co,
  output logic             ovf,
  output logic             load_err
);

  // Reject parameter sets the counter cannot represent.
  generate
    if (!params_legal(WIDTH, MODULUS)) begin : g_param_check
      $error("sync_up_counter: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
    end
  endgenerate

  logic w_tc;
  logic w_ovf_set;
  logic w_clamp;
  logic r_ovf;
  logic r_load_err;

  up_count_core #(
    .WIDTH    (WIDTH),
    .MODULUS  (MODULUS),
    .SATURATE (SATURATE)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .tc       (w_tc),
    .ovf_set  (w_ovf_set),
    .clamp    (w_clamp)
  );

  // Sticky overflow: a set on the same edge as a clear takes precedence.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  // One-cycle pulse following every clamped load edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_load_err <= 1'b0;
    end else begin
      r_load_err <= w_clamp;
    end
  end

  assign tc       = w_tc;
  // Carry only when this stage will actually roll on the coming edge.
  assign co       = w_tc & en & ~load;
  assign ovf      = r_ovf;
  assign load_err = r_load_err;

endmodule : sync_up_counter
`default_nettype wire

// File: tb/tb_sync_up_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_up_counter
// Brief    : Self-checking bench: wrap counter, mod-10 saturating counter and
//            a two-stage cascade, with a reference model feeding a scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_up_counter;

  typedef struct {
    int q;
    bit ovf;
    bit lerr;
  } st_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=4, MODULUS=16, wrap
  logic       a_rst = 1'b1, a_en = 1'b0, a_load = 1'b0, a_clr = 1'b0;
  logic [3:0] a_lv = '0;
  logic [3:0] a_q;
  logic       a_tc, a_co, a_ovf, a_lerr;

  // Instance B: WIDTH=4, MODULUS=10, saturate
  logic       b_rst = 1'b1, b_en = 1'b0, b_load = 1'b0, b_clr = 1'b0;
  logic [3:0] b_lv = '0;
  logic [3:0] b_q;
  logic       b_tc, b_co, b_ovf, b_lerr;

  // Cascade: lo.co drives hi.en
  logic       c_rst = 1'b1, c_en = 1'b0;
  logic [3:0] lo_q, hi_q;
  logic       lo_tc, lo_co, lo_ovf, lo_lerr;
  logic       hi_tc, hi_co, hi_ovf, hi_lerr;

  sync_up_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) dut_a (
    .clk(clk), .rst(a_rst), .en(a_en), .load(a_load), .load_val(a_lv),
    .clr_ovf(a_clr), .q(a_q), .tc(a_tc), .co(a_co), .ovf(a_ovf), .load_err(a_lerr));

  sync_up_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_b (
    .clk(clk), .rst(b_rst), .en(b_en), .load(b_load), .load_val(b_lv),
    .clr_ovf(b_clr), .q(b_q), .tc(b_tc), .co(b_co), .ovf(b_ovf), .load_err(b_lerr));

  sync_up_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) dut_lo (
    .clk(clk), .rst(c_rst), .en(c_en), .load(1'b0), .load_val(4'd0),
    .clr_ovf(1'b0), .q(lo_q), .tc(lo_tc), .co(lo_co), .ovf(lo_ovf), .load_err(lo_lerr));

  sync_up_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) dut_hi (
    .clk(clk), .rst(c_rst), .en(lo_co), .load(1'b0), .load_val(4'd0),
    .clr_ovf(1'b0), .q(hi_q), .tc(hi_tc), .co(hi_co), .ovf(hi_ovf), .load_err(hi_lerr));

  int  checks = 0;
  int  errors = 0;
  st_t ma = '{q: 0, ovf: 1'b0, lerr: 1'b0};
  st_t mb = '{q: 0, ovf: 1'b0, lerr: 1'b0};
  st_t sba[$];
  st_t sbb[$];
  int  sbc[$];
  int  ccnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one clock edge.
  function automatic st_t mstep(st_t s, int m, bit sat, bit r, bit e, bit l, int lv, bit c);
    st_t n;
    bit  set;
    n      = s;
    n.lerr = 1'b0;
    set    = !l && e && (s.q == m - 1);
    if (r) begin
      n.q   = 0;
      n.ovf = 1'b0;
    end else begin
      if (l) begin
        if (lv < m) n.q = lv;
        else begin
          n.q    = m - 1;
          n.lerr = 1'b1;
        end
      end else if (e) begin
        if (s.q < m - 1) n.q = s.q + 1;
        else if (!sat) n.q = 0;
      end
      if (set) n.ovf = 1'b1;
      else if (c) n.ovf = 1'b0;
    end
    return n;
  endfunction

  task automatic step_a(input bit r, input bit e, input bit l, input int lv, input bit c);
    st_t x;
    a_rst = r; a_en = e; a_load = l; a_lv = lv[3:0]; a_clr = c;
    #1;
    if (!r) chk("a_co", a_co, (ma.q == 15) && e && !l);
    ma = mstep(ma, 16, 1'b0, r, e, l, lv, c);
    sba.push_back(ma);
    @(posedge clk); #1;
    x = sba.pop_front();
    chk("a_q", a_q, x.q);
    chk("a_tc", a_tc, x.q == 15);
    chk("a_ovf", a_ovf, x.ovf);
    chk("a_lerr", a_lerr, x.lerr);
  endtask

  task automatic step_b(input bit r, input bit e, input bit l, input int lv, input bit c);
    st_t x;
    b_rst = r; b_en = e; b_load = l; b_lv = lv[3:0]; b_clr = c;
    #1;
    if (!r) chk("b_co", b_co, (mb.q == 9) && e && !l);
    mb = mstep(mb, 10, 1'b1, r, e, l, lv, c);
    sbb.push_back(mb);
    @(posedge clk); #1;
    x = sbb.pop_front();
    chk("b_q", b_q, x.q);
    chk("b_tc", b_tc, x.q == 9);
    chk("b_ovf", b_ovf, x.ovf);
    chk("b_lerr", b_lerr, x.lerr);
  endtask

  task automatic step_c(input bit r, input bit e);
    int x;
    c_rst = r; c_en = e;
    #1;
    if (r) ccnt = 0;
    else if (e) ccnt = (ccnt + 1) % 256;
    sbc.push_back(ccnt);
    @(posedge clk); #1;
    x = sbc.pop_front();
    chk("casc_val", {24'd0, hi_q, lo_q}, x);
  endtask

  initial begin
    // Reset and free-run through one full period
    step_a(1, 0, 0, 0, 0);
    step_a(1, 0, 0, 0, 0);
    chk("a_co_reset", a_co, 0);
    for (int i = 0; i < 16; i++) step_a(0, 1, 0, 0, 0);
    step_a(0, 0, 0, 0, 0);

    // Priority: load beats enable at terminal count
    for (int i = 0; i < 15; i++) step_a(0, 1, 0, 0, 0);
    step_a(0, 1, 1, 3, 0);
    step_a(1, 0, 1, 9, 0);

    // Overflow set/clear race, then plain clear
    for (int i = 0; i < 15; i++) step_a(0, 1, 0, 0, 0);
    step_a(0, 1, 0, 0, 1);
    step_a(0, 0, 0, 0, 1);
    step_a(0, 1, 0, 0, 1);

    // Modulo 10 with saturate
    step_b(1, 0, 0, 0, 0);
    step_b(1, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) step_b(0, 1, 0, 0, 0);

    // Load and clamp, including back-to-back clamped loads
    step_b(0, 0, 1, 7, 0);
    step_b(0, 0, 1, 12, 0);
    step_b(0, 0, 0, 0, 0);
    step_b(0, 1, 1, 15, 0);
    step_b(0, 0, 1, 13, 0);
    step_b(0, 0, 1, 2, 1);
    step_b(0, 1, 0, 0, 0);

    // Cascade from reset
    step_c(1, 0);
    step_c(1, 0);
    for (int i = 0; i < 300; i++) step_c(0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sync_up_counter
`default_nettype wire
